// File: rtl/led_blink_array.sv
// Multi-channel LED driver: OFF / ON / BLINK / PWM per channel.
// Shared tick prescaler, run-time config through a valid/ready write port.
//
// Ports:
//   clk        system clock (PLL output), all logic on posedge
//   rst        synchronous reset, active high
//   cfg_valid  config write request
//   cfg_ready  write port can accept (FSM in IDLE)
//   cfg_chan   target channel index
//   cfg_mode   0=OFF 1=ON 2=BLINK 3=PWM
//   cfg_period BLINK half-period minus one, in ticks
//   cfg_duty   PWM on-ticks per frame
//   cfg_err    1-cycle pulse while committing to a nonexistent channel
//   tick       1-cycle prescaler pulse (registered)
//   led        registered LED outputs
module led_blink_array #(
  parameter int CHANNELS   = 3,
  parameter int CNT_WIDTH  = 25,
  parameter int PRESCALE   = 2700,
  parameter int DUTY_WIDTH = 8,
  parameter int CH_W       = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CH_W-1:0]       cfg_chan,
  input  logic [1:0]            cfg_mode,
  input  logic [CNT_WIDTH-1:0]  cfg_period,
  input  logic [DUTY_WIDTH-1:0] cfg_duty,
  output logic                  cfg_err,
  output logic                  tick,
  output logic [CHANNELS-1:0]   led
);

  localparam int PS_W =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_MAX =
    PS_W'(PRESCALE - 1);
  localparam logic [CH_W:0] CH_LIM =
    (CH_W+1)'(CHANNELS);

  typedef enum logic [1:0] {
    M_OFF   = 2'd0,
    M_ON    = 2'd1,
    M_BLINK = 2'd2,
    M_PWM   = 2'd3
  } mode_e;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_COMMIT = 1'b1
  } state_e;

  // prescaler
  logic [PS_W-1:0] ps_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      ps_cnt <= '0;
      tick   <= 1'b0;
    end else begin
      tick <= (ps_cnt == PS_MAX);
      if (ps_cnt == PS_MAX)
        ps_cnt <= '0;
      else
        ps_cnt <= ps_cnt + PS_W'(1);
    end
  end

  // config FSM
  state_e state_q;
  state_e state_d;
  logic   commit;
  logic   chan_ok;

  logic [CH_W-1:0]       h_chan;
  mode_e                 h_mode;
  logic [CNT_WIDTH-1:0]  h_period;
  logic [DUTY_WIDTH-1:0] h_duty;

  assign chan_ok = ({1'b0, h_chan} < CH_LIM);

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cfg_ready = 1'b0;
    commit    = 1'b0;
    cfg_err   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid)
          state_d = S_COMMIT;
      end
      S_COMMIT: begin
        commit  = 1'b1;
        cfg_err = ~chan_ok;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_chan   <= '0;
      h_mode   <= M_OFF;
      h_period <= '0;
      h_duty   <= '0;
    end else if (cfg_ready && cfg_valid) begin
      h_chan   <= cfg_chan;
      h_mode   <= mode_e'(cfg_mode);
      h_period <= cfg_period;
      h_duty   <= cfg_duty;
    end
  end

  // channels
  mode_e                 mode_q  [CHANNELS];
  logic [CNT_WIDTH-1:0]  period_q[CHANNELS];
  logic [DUTY_WIDTH-1:0] duty_q  [CHANNELS];
  logic [CNT_WIDTH-1:0]  phase_q [CHANNELS];
  logic [DUTY_WIDTH-1:0] pwm_nxt [CHANNELS];
  logic [CHANNELS-1:0]   hit;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      pwm_nxt[i] = phase_q[i][DUTY_WIDTH-1:0]
                 + DUTY_WIDTH'(1);
      hit[i] = commit && chan_ok
            && (h_chan == CH_W'(i));
    end
  end

  // a commit owns its channel on that edge;
  // any coincident tick is dropped for it
  always_ff @(posedge clk) begin
    if (rst) begin
      led <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        mode_q[i]   <= M_OFF;
        period_q[i] <= '0;
        duty_q[i]   <= '0;
        phase_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (hit[i]) begin
          mode_q[i]   <= h_mode;
          period_q[i] <= h_period;
          duty_q[i]   <= h_duty;
          phase_q[i]  <= '0;
          unique case (h_mode)
            M_OFF:   led[i] <= 1'b0;
            M_ON:    led[i] <= 1'b1;
            M_BLINK: led[i] <= 1'b0;
            M_PWM:   led[i] <= (h_duty != '0);
            default: led[i] <= 1'b0;
          endcase
        end else if (tick) begin
          unique case (mode_q[i])
            M_BLINK: begin
              if (phase_q[i] == period_q[i]) begin
                phase_q[i] <= '0;
                led[i]     <= ~led[i];
              end else begin
                phase_q[i] <= phase_q[i]
                            + CNT_WIDTH'(1);
              end
            end
            M_PWM: begin
              phase_q[i] <= CNT_WIDTH'(pwm_nxt[i]);
              led[i]     <= (pwm_nxt[i] < duty_q[i]);
            end
            default: phase_q[i] <= '0;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_led_blink_array.sv
// Self-checking bench for led_blink_array.
// Closed-form per-channel model driven by ticks elapsed since commit.
module tb_led_blink_array;

  localparam int CH  = 3;
  localparam int CW  = 25;
  localparam int P   = 4;
  localparam int DW  = 8;
  localparam int CHW = 2;
  localparam int FR  = 1 << DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [CHW-1:0] cfg_chan;
  logic [1:0]    cfg_mode;
  logic [CW-1:0] cfg_period;
  logic [DW-1:0] cfg_duty;
  logic          cfg_err;
  logic          tick;
  logic [CH-1:0] led;

  always #5 clk = ~clk;

  led_blink_array #(
    .CHANNELS  (CH),
    .CNT_WIDTH (CW),
    .PRESCALE  (P),
    .DUTY_WIDTH(DW),
    .CH_W      (CHW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_mode  (cfg_mode),
    .cfg_period(cfg_period),
    .cfg_duty  (cfg_duty),
    .cfg_err   (cfg_err),
    .tick      (tick),
    .led       (led)
  );

  int n_cmp = 0;
  int n_bad = 0;
  string ph = "init";

  // model state
  bit m_commit;
  int m_hchan, m_hmode, m_hper, m_hduty;
  bit m_tick;
  int m_ps;
  int m_mode[CH];
  int m_per [CH];
  int m_duty[CH];
  int m_t   [CH];
  bit tick_edge;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  function automatic bit exp_led(input int c);
    case (m_mode[c])
      1:       return 1'b1;
      2:       return ((m_t[c] / (m_per[c] + 1)) % 2) == 1;
      3:       return (m_t[c] % FR) < m_duty[c];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [CH-1:0] exp_vec();
    logic [CH-1:0] v;
    for (int c = 0; c < CH; c++) v[c] = exp_led(c);
    return v;
  endfunction

  task automatic step();
    bit c_now;
    bit t_now;
    c_now = 1'b0;
    t_now = 1'b0;
    if (rst) begin
      m_commit = 1'b0;
      m_hchan = 0; m_hmode = 0;
      m_hper = 0;  m_hduty = 0;
      m_tick = 1'b0;
      m_ps = 0;
      for (int c = 0; c < CH; c++) begin
        m_mode[c] = 0; m_per[c] = 0;
        m_duty[c] = 0; m_t[c] = 0;
      end
    end else begin
      c_now  = m_commit;
      t_now  = m_tick;
      m_tick = (m_ps == P - 1);
      m_ps   = (m_ps + 1) % P;
      for (int c = 0; c < CH; c++) begin
        if (c_now && m_hchan == c) begin
          m_mode[c] = m_hmode;
          m_per[c]  = m_hper;
          m_duty[c] = m_hduty;
          m_t[c]    = 0;
        end else if (t_now) begin
          m_t[c]++;
        end
      end
      if (!c_now && cfg_valid) begin
        m_commit = 1'b1;
        m_hchan = int'(cfg_chan);
        m_hmode = int'(cfg_mode);
        m_hper  = int'(cfg_period);
        m_hduty = int'(cfg_duty);
      end else begin
        m_commit = 1'b0;
      end
    end
    tick_edge = t_now;
    @(posedge clk);
    #1;
    chk({ph, ":ready"}, 32'(cfg_ready), 32'(!m_commit));
    chk({ph, ":err"}, 32'(cfg_err),
        32'(m_commit && m_hchan >= CH));
    chk({ph, ":tick"}, 32'(tick), 32'(m_tick));
    chk({ph, ":led"}, 32'(led), 32'(exp_vec()));
  endtask

  task automatic wr(input int ch, input int md,
                    input int per, input int dt);
    int guard;
    guard = 0;
    while (m_commit && guard < 4) begin
      step();
      guard++;
    end
    cfg_valid  = 1'b1;
    cfg_chan   = CHW'(ch);
    cfg_mode   = 2'(md);
    cfg_period = CW'(per);
    cfg_duty   = DW'(dt);
    step();
    cfg_valid  = 1'b0;
    step();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    int tog, hi, guard;
    logic pl;
    rst = 1'b1; cfg_valid = 1'b1;
    cfg_chan = '0; cfg_mode = 2'd1;
    cfg_period = '0; cfg_duty = '0;

    ph = "reset";
    run(3);
    rst = 1'b0; cfg_valid = 1'b0;
    run(2);

    ph = "blink";
    wr(0, 2, 2, 0);
    tog = 0; pl = led[0];
    for (int k = 0; k < 62; k++) begin
      step();
      if (led[0] !== pl) tog++;
      pl = led[0];
    end
    chk("blink_toggles", 32'(tog), 32'(m_t[0] / 3));

    ph = "pwm";
    wr(1, 3, 0, 64);
    hi = 0;
    guard = 0;
    for (int k = 0; k < FR && guard < 2000; ) begin
      step();
      guard++;
      if (tick_edge) begin
        k++;
        if (led[1]) hi++;
      end
    end
    chk("pwm_high", 32'(hi), 32'd64);

    ph = "burst";
    cfg_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cfg_chan = CHW'(k % 3);
      cfg_mode = 2'(k % 4);
      cfg_duty = DW'(k * 40);
      cfg_period = CW'(k);
      step();
    end
    cfg_valid = 1'b0;
    run(3);

    ph = "badchan";
    wr(3, 1, 0, 0);
    run(4);

    ph = "coinc";
    wr(2, 2, 0, 0);
    guard = 0;
    while ((m_commit || m_ps != P - 1) && guard < 16) begin
      step();
      guard++;
    end
    chk("coinc_align", 32'(m_ps), 32'(P - 1));
    cfg_valid = 1'b1; cfg_chan = 2'd0;
    cfg_mode = 2'd2; cfg_period = CW'(1);
    step();
    cfg_valid = 1'b0;
    step();
    chk("coinc_led0", 32'(led[0]), 32'd0);
    run(10);
    rst = 1'b1;
    step();
    chk("midrst_led", 32'(led), 32'd0);
    rst = 1'b0;

    ph = "random";
    for (int k = 0; k < 4000; k++) begin
      cfg_valid  = ($urandom_range(0, 3) == 0);
      cfg_chan   = CHW'($urandom_range(0, 3));
      cfg_mode   = 2'($urandom_range(0, 3));
      cfg_period = CW'($urandom_range(0, 4));
      case ($urandom_range(0, 4))
        0:       cfg_duty = '0;
        1:       cfg_duty = DW'(FR - 1);
        2:       cfg_duty = DW'(1);
        default: cfg_duty = DW'($urandom);
      endcase
      rst = ($urandom_range(0, 799) == 0);
      step();
    end
    rst = 1'b0;
    cfg_valid = 1'b0;
    run(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
